pwm_capture: RTL and testbench

PWM input-capture block. It measures the period and high time of an external PWM waveform in prescaled clock ticks, which makes it the receive-side counterpart of the team's PWM generator. It sits beside the PWM core in the timer subsystem and feeds a register interface or a loopback self-test. One valid pulse is produced per complete PWM cycle.

---
 rtl/pwm_capture.sv | 168 ++++++++++++++++
 tb/tb_pwm_capture.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM input capture: period and high time in prescaled ticks
// Optional glitch filter on the synchronized input: define PWM_CAPTURE_FILTER_EN
module pwm_capture #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [15:0] prescaler,
  input  logic [15:0] timeout,
  input  logic        pwm_in,
  output logic [15:0] measured_period,
  output logic [15:0] measured_high,
  output logic        capture_valid,
  output logic        capture_timeout,
  output logic        overflow,
  output logic        capturing
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_HIGH, S_LOW} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pwm_s, pwm_f, pwm_d, rise, fall;
  logic [15:0]            psc_cnt, div_m1, per_cnt, high_cnt, per_inc, high_inc;
  logic [15:0]            period_nxt, high_nxt;
  logic                   ovf_nxt, tick, active, do_capture, do_timeout, restart;

  if (SYNC_STAGES < 2 || FILTER_LEN < 1) begin : g_param_check
    $error("pwm_capture: SYNC_STAGES must be >= 2 and FILTER_LEN >= 1");
  end

  // Metastability chain on the asynchronous PWM input
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
  end

  assign pwm_s = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);
  logic [FW-1:0] flt_cnt;
  logic          flt_lvl;

  // Accept a new level only after FILTER_LEN consecutive disagreeing samples
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flt_cnt <= '0;
      flt_lvl <= 1'b0;
    end else if (pwm_s == flt_lvl) begin
      flt_cnt <= '0;
    end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
      flt_lvl <= pwm_s;
      flt_cnt <= '0;
    end else begin
      flt_cnt <= flt_cnt + 1'b1;
    end
  end

  assign pwm_f = flt_lvl;
`else
  assign pwm_f = pwm_s;
`endif

  // Delayed copy of the level for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pwm_d <= 1'b0;
    else          pwm_d <= pwm_f;
  end

  assign rise = pwm_f & ~pwm_d;
  assign fall = ~pwm_f & pwm_d;

  // Tick arithmetic; the >= keeps ticking sane if prescaler shrinks mid-count
  assign div_m1     = (prescaler == 16'd0) ? 16'd0 : prescaler - 16'd1;
  assign tick       = (psc_cnt >= div_m1);
  assign active     = enable && (state != S_IDLE);
  assign per_inc    = (tick && per_cnt != 16'hFFFF) ? per_cnt + 16'd1 : per_cnt;
  assign high_inc   = (tick && state == S_HIGH && high_cnt != 16'hFFFF) ? high_cnt + 16'd1 : high_cnt;
  assign do_capture = active && rise && (state == S_HIGH || state == S_LOW);
  assign do_timeout = active && !rise && (timeout != 16'd0) && tick && (per_inc == timeout);
  assign restart    = !active || rise || do_timeout;
  assign capturing  = (state != S_IDLE);

  // Prescaler divider, re-phased on every rise so ticks align to the PWM cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                    psc_cnt <= 16'd0;
    else if (!active || rise || tick) psc_cnt <= 16'd0;
    else                             psc_cnt <= psc_cnt + 16'd1;
  end

  // Period and high-time tick counters, saturating, restarted per measurement
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      per_cnt  <= 16'd0;
      high_cnt <= 16'd0;
    end else if (restart) begin
      per_cnt  <= 16'd0;
      high_cnt <= 16'd0;
    end else begin
      per_cnt  <= per_inc;
      high_cnt <= high_inc;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next state: a rise always wins over a coincident timeout
  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: state_nxt = S_ARM;
        S_ARM:  if (rise) state_nxt = S_HIGH;
                else if (do_timeout) state_nxt = S_ARM;
        S_HIGH: if (rise) state_nxt = S_HIGH;
                else if (do_timeout) state_nxt = S_ARM;
                else if (fall) state_nxt = S_LOW;
        S_LOW:  if (rise) state_nxt = S_HIGH;
                else if (do_timeout) state_nxt = S_ARM;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Result values; a rise in HIGH means the fall was missed, so high = period
  always_comb begin
    period_nxt = measured_period;
    high_nxt   = measured_high;
    ovf_nxt    = overflow;
    if (do_capture) begin
      period_nxt = per_inc;
      high_nxt   = (state == S_HIGH) ? per_inc : high_inc;
      ovf_nxt    = (per_inc == 16'hFFFF) || (high_nxt == 16'hFFFF);
    end else if (do_timeout) begin
      period_nxt = 16'd0;
      high_nxt   = {16{pwm_f}};
    end else if (active && (per_inc == 16'hFFFF || high_inc == 16'hFFFF)) begin
      ovf_nxt = 1'b1;
    end
  end

  // Registered outputs; pulses last exactly one clock
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      measured_period <= 16'd0;
      measured_high   <= 16'd0;
      overflow        <= 1'b0;
      capture_valid   <= 1'b0;
      capture_timeout <= 1'b0;
    end else begin
      measured_period <= period_nxt;
      measured_high   <= high_nxt;
      overflow        <= ovf_nxt;
      capture_valid   <= do_capture;
      capture_timeout <= do_timeout;
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - scoreboard bench for pwm_capture against an edge-timestamp reference model
`timescale 1ns/1ps
module tb_pwm_capture;

  localparam int SYNC_STAGES = 2;
  localparam int FILTER_LEN  = 3;
`ifdef PWM_CAPTURE_FILTER_EN
  localparam int LAT = SYNC_STAGES + 1 + FILTER_LEN;
`else
  localparam int LAT = SYNC_STAGES + 1;
`endif

  logic        clk = 1'b0;
  logic        reset_n, enable, pwm_in;
  logic [15:0] prescaler, timeout;
  logic [15:0] measured_period, measured_high;
  logic        capture_valid, capture_timeout, overflow, capturing;

  pwm_capture #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .enable          (enable),
    .prescaler       (prescaler),
    .timeout         (timeout),
    .pwm_in          (pwm_in),
    .measured_period (measured_period),
    .measured_high   (measured_high),
    .capture_valid   (capture_valid),
    .capture_timeout (capture_timeout),
    .overflow        (overflow),
    .capturing       (capturing)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_to;
    int per;
    int hi;
    bit ovf;
    int at;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // reference model state: timestamps of input edges while capture is enabled
  bit m_en, m_have, m_fall;
  int m_rise_c, m_fall_c, m_div;

  function automatic int sat16(int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // monitor: pop and compare whenever the DUT reports a result
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && (capture_valid || capture_timeout)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_kind_timeout", int'(capture_timeout), int'(e.is_to));
        chk("pulse_cycle", cyc, e.at);
        chk("measured_period", int'(measured_period), e.per);
        chk("measured_high", int'(measured_high), e.hi);
        if (!e.is_to) chk("overflow", int'(overflow), int'(e.ovf));
      end
    end
  end

  task automatic wait_cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_level(bit v);
    int n, h;
    if (v == pwm_in) return;
    pwm_in = v;
    if (v) begin
      if (m_en && m_have) begin
        n = cyc - m_rise_c;
        h = m_fall ? (m_fall_c - m_rise_c) : n;
        exp_q.push_back('{1'b0, sat16(n / m_div), sat16(h / m_div),
                          (n / m_div >= 65535) || (h / m_div >= 65535), cyc + LAT});
      end
      m_have   = m_en;
      m_rise_c = cyc;
      m_fall   = 1'b0;
    end else if (m_have) begin
      m_fall   = 1'b1;
      m_fall_c = cyc;
    end
  endtask

  task automatic low_glitch(int len);
`ifdef PWM_CAPTURE_FILTER_EN
    if (len < FILTER_LEN) begin
      pwm_in = 1'b0;
      wait_cyc(len);
      pwm_in = 1'b1;
      return;
    end
`endif
    set_level(1'b0);
    wait_cyc(len);
    set_level(1'b1);
  endtask

  task automatic run_pwm(int period, int high, int n);
    repeat (n) begin
      set_level(1'b1);
      wait_cyc(high);
      set_level(1'b0);
      wait_cyc(period - high);
    end
  endtask

  task automatic set_enable(bit v);
    enable = v;
    m_en   = v;
    if (!v) m_have = 1'b0;
  endtask

  task automatic set_cfg(int psc, int to);
    set_enable(1'b0);
    wait_cyc(3);
    prescaler = 16'(psc);
    timeout   = 16'(to);
    m_div     = (psc == 0) ? 1 : psc;
    wait_cyc(2);
    set_enable(1'b1);
    wait_cyc(3);
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_period"}, int'(measured_period), 0);
    chk({tag, "_high"}, int'(measured_high), 0);
    chk({tag, "_valid"}, int'(capture_valid), 0);
    chk({tag, "_timeout"}, int'(capture_timeout), 0);
    chk({tag, "_overflow"}, int'(overflow), 0);
    chk({tag, "_capturing"}, int'(capturing), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c, h, l;
    reset_n = 1'b0; enable = 1'b0; prescaler = 16'd0; timeout = 16'd0; pwm_in = 1'b0;
    m_en = 1'b0; m_have = 1'b0; m_fall = 1'b0; m_rise_c = 0; m_fall_c = 0; m_div = 1;
    wait_cyc(3);
    chk_all_zero("reset");
    reset_n = 1'b1;
    wait_cyc(2);
    set_enable(1'b1);
    wait_cyc(2);
    chk("capturing_after_enable", int'(capturing), 1);

    // basic: period 10, high 3, no prescaler
    run_pwm(10, 3, 4);

    // prescaled
    set_cfg(4, 0);
    run_pwm(400, 100, 3);

    // stuck-high timeout then recovery
    set_cfg(0, 50);
    set_level(1'b1);
    c = cyc;
    exp_q.push_back('{1'b1, 0, 65535, 1'b0, c + LAT + 50});
    m_have = 1'b0;
    wait_cyc(60);
    chk("capturing_after_timeout", int'(capturing), 1);
    set_level(1'b0);
    wait_cyc(5);
    run_pwm(10, 3, 3);

    // saturation and recovery
    set_cfg(0, 0);
    run_pwm(100, 30, 1);
    run_pwm(65600, 100, 1);
    run_pwm(100, 30, 2);

    // randomized waveforms and prescalers
    for (int r = 0; r < 4; r++) begin
      set_cfg(int'($urandom_range(0, 4)), 0);
      for (int i = 0; i < 6; i++) begin
        h = int'($urandom_range(3, 40));
        l = int'($urandom_range(3, 40));
        run_pwm(h + l, h, 1);
      end
    end

    // 2-clk low glitch inside the high phase
    set_cfg(0, 0);
    run_pwm(30, 10, 1);
    set_level(1'b1);
    wait_cyc(4);
    low_glitch(2);
    wait_cyc(6);
    set_level(1'b0);
    wait_cyc(18);
    run_pwm(30, 10, 1);

    // enable dropped in the middle of LOW
    set_cfg(0, 0);
    run_pwm(20, 5, 2);
    set_level(1'b1);
    wait_cyc(5);
    set_level(1'b0);
    wait_cyc(6);
    set_enable(1'b0);
    wait_cyc(4);
    set_enable(1'b1);
    wait_cyc(4);
    run_pwm(20, 5, 3);

    // asynchronous reset in the middle of HIGH
    set_level(1'b1);
    wait_cyc(4);
    reset_n = 1'b0;
    m_have  = 1'b0;
    #1;
    chk_all_zero("async_reset");
    wait_cyc(2);
    reset_n = 1'b1;
    wait_cyc(10);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
